// File: rtl/enable_sequencer.sv
// Enable sequencer: delayed LSB-first power-up, MSB-first power-down, fault kill.
// Optional build macro SEQ_FAULT_LATCH_EN makes FAULT sticky until clear.
module enable_sequencer #(
    parameter int N_CH        = 4,
    parameter int START_DELAY = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            fault,
    input  logic            clear,
    output logic [N_CH-1:0] enable_out,
    output logic            busy,
    output logic            ready,
    output logic            fault_flag
);

    localparam int MAXD = (START_DELAY > STEP_CYCLES) ? START_DELAY : STEP_CYCLES;
    localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    localparam logic [CW-1:0] START_LOAD = CW'(START_DELAY - 1);
    localparam logic [CW-1:0] STEP_LOAD  = CW'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_UP,
        S_RUN,
        S_DOWN,
        S_FAULT
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [N_CH-1:0] en_n;
    logic            busy_n, ready_n, flag_n;
    logic            fault_exit;

`ifdef SEQ_FAULT_LATCH_EN
    assign fault_exit = clear & ~fault;
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign fault_exit   = ~fault;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            enable_out <= '0;
            busy       <= 1'b0;
            ready      <= 1'b0;
            fault_flag <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            enable_out <= en_n;
            busy       <= busy_n;
            ready      <= ready_n;
            fault_flag <= flag_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        en_n    = enable_out;
        ready_n = ready;
        if (fault && state != S_FAULT) begin
            state_n = S_FAULT;
            cnt_n   = '0;
            en_n    = '0;
            ready_n = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_n = S_WAIT;
                        cnt_n   = START_LOAD;
                    end
                end
                S_WAIT: begin
                    if (stop) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else if (cnt == '0) begin
                        state_n = S_UP;
                        en_n    = N_CH'(1);
                        cnt_n   = STEP_LOAD;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                S_UP, S_RUN: begin
                    if (stop) begin
                        // Enables are contiguous from bit 0, so a right shift drops the top one.
                        en_n    = enable_out >> 1;
                        ready_n = 1'b0;
                        if ((enable_out >> 1) == '0) begin
                            state_n = S_IDLE;
                            cnt_n   = '0;
                        end else begin
                            state_n = S_DOWN;
                            cnt_n   = STEP_LOAD;
                        end
                    end else if (state == S_UP) begin
                        if (cnt != '0) begin
                            cnt_n = cnt - CW'(1);
                        end else if (enable_out[N_CH-1]) begin
                            state_n = S_RUN;
                            ready_n = 1'b1;
                        end else begin
                            en_n  = (enable_out << 1) | N_CH'(1);
                            cnt_n = STEP_LOAD;
                        end
                    end
                end
                S_DOWN: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - CW'(1);
                    end else begin
                        en_n = enable_out >> 1;
                        if ((enable_out >> 1) == '0) begin
                            state_n = S_IDLE;
                        end else begin
                            cnt_n = STEP_LOAD;
                        end
                    end
                end
                S_FAULT: begin
                    if (fault_exit) begin
                        state_n = S_IDLE;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    en_n    = '0;
                    ready_n = 1'b0;
                end
            endcase
        end
        busy_n = (state_n == S_WAIT) || (state_n == S_UP) ||
                 (state_n == S_RUN)  || (state_n == S_DOWN);
        flag_n = (state_n == S_FAULT);
    end

endmodule

// File: tb/tb_enable_sequencer.sv
// Vector-table bench for enable_sequencer with a scoreboard queue of expectations.
// Each vector drives its inputs on the first edge only, then idles for the rest.
module tb_enable_sequencer;

    typedef struct {
        int         id;
        int         cycles;
        logic       start;
        logic       stop;
        logic       fault;
        logic       clear;
        logic [3:0] en;
        logic       busy;
        logic       ready;
        logic       flag;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       fault = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] enable_out;
    logic       busy;
    logic       ready;
    logic       fault_flag;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    enable_sequencer #(
        .N_CH(4),
        .START_DELAY(16),
        .STEP_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .start(start),
        .stop(stop),
        .fault(fault),
        .clear(clear),
        .enable_out(enable_out),
        .busy(busy),
        .ready(ready),
        .fault_flag(fault_flag)
    );

    function automatic vec_t mk(int id, int cyc, logic st, logic sp, logic ft,
                                logic cl, logic [3:0] en, logic b, logic r, logic f);
        vec_t v;
        v.id = id; v.cycles = cyc;
        v.start = st; v.stop = sp; v.fault = ft; v.clear = cl;
        v.en = en; v.busy = b; v.ready = r; v.flag = f;
        return v;
    endfunction

    task automatic chk(string nm, int id, logic [3:0] got, logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s step %0d: got %b want %b", nm, id, got, want);
        end
    endtask

    task automatic compare_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: empty queue");
            return;
        end
        e = exp_q.pop_front();
        chk("enable_out", e.id, enable_out, e.en);
        chk("busy", e.id, {3'b0, busy}, {3'b0, e.busy});
        chk("ready", e.id, {3'b0, ready}, {3'b0, e.ready});
        chk("fault_flag", e.id, {3'b0, fault_flag}, {3'b0, e.flag});
    endtask

    task automatic run_vec(vec_t v);
        @(negedge clk);
        start = v.start; stop = v.stop; fault = v.fault; clear = v.clear;
        exp_q.push_back(v);
        @(posedge clk);
        for (int k = 1; k < v.cycles; k++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0; fault = 1'b0; clear = 1'b0;
            @(posedge clk);
        end
        #1;
        compare_out();
        start = 1'b0; stop = 1'b0; fault = 1'b0; clear = 1'b0;
    endtask

    initial begin
        // Power-up ramp: start sampled at edge E.
        vecs.push_back(mk( 0,  2, 1, 0, 0, 0, 4'b0000, 1, 0, 0));
        vecs.push_back(mk( 1, 14, 0, 0, 0, 0, 4'b0000, 1, 0, 0));
        vecs.push_back(mk( 2,  1, 0, 0, 0, 0, 4'b0001, 1, 0, 0));
        vecs.push_back(mk( 3,  7, 0, 0, 0, 0, 4'b0001, 1, 0, 0));
        vecs.push_back(mk( 4,  1, 0, 0, 0, 0, 4'b0011, 1, 0, 0));
        vecs.push_back(mk( 5,  8, 0, 0, 0, 0, 4'b0111, 1, 0, 0));
        vecs.push_back(mk( 6,  8, 0, 0, 0, 0, 4'b1111, 1, 0, 0));
        vecs.push_back(mk( 7,  7, 0, 0, 0, 0, 4'b1111, 1, 0, 0));
        vecs.push_back(mk( 8,  1, 0, 0, 0, 0, 4'b1111, 1, 1, 0));
        vecs.push_back(mk( 9,  5, 1, 0, 0, 0, 4'b1111, 1, 1, 0));
        // Ramp-down from RUN, stop at edge S.
        vecs.push_back(mk(10,  1, 0, 1, 0, 0, 4'b0111, 1, 0, 0));
        vecs.push_back(mk(11,  8, 0, 0, 0, 0, 4'b0011, 1, 0, 0));
        vecs.push_back(mk(12,  8, 0, 0, 0, 0, 4'b0001, 1, 0, 0));
        vecs.push_back(mk(13,  7, 0, 0, 0, 0, 4'b0001, 1, 0, 0));
        vecs.push_back(mk(14,  1, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(15,  3, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        // start+stop together in IDLE, then stop during WAIT.
        vecs.push_back(mk(16,  1, 1, 1, 0, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(17, 20, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(18,  1, 1, 0, 0, 0, 4'b0000, 1, 0, 0));
        vecs.push_back(mk(19,  5, 0, 0, 0, 0, 4'b0000, 1, 0, 0));
        vecs.push_back(mk(20,  1, 0, 1, 0, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(21, 20, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        // Fault while UP at 0011.
        vecs.push_back(mk(22,  1, 1, 0, 0, 0, 4'b0000, 1, 0, 0));
        vecs.push_back(mk(23, 25, 0, 0, 0, 0, 4'b0011, 1, 0, 0));
        vecs.push_back(mk(24,  1, 0, 0, 1, 0, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(25,  1, 0, 0, 1, 0, 4'b0000, 0, 0, 1));
`ifdef SEQ_FAULT_LATCH_EN
        vecs.push_back(mk(26,  1, 1, 0, 0, 0, 4'b0000, 0, 0, 1));
`else
        vecs.push_back(mk(26,  1, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
`endif
        vecs.push_back(mk(27, 20, 0, 0, 0, 1, 4'b0000, 0, 0, 0));
        // start/stop ignored during DOWN.
        vecs.push_back(mk(28, 49, 1, 0, 0, 0, 4'b1111, 1, 1, 0));
        vecs.push_back(mk(29,  1, 0, 1, 0, 0, 4'b0111, 1, 0, 0));
        vecs.push_back(mk(30,  8, 1, 0, 0, 0, 4'b0011, 1, 0, 0));
        vecs.push_back(mk(31,  8, 0, 1, 0, 0, 4'b0001, 1, 0, 0));
        vecs.push_back(mk(32,  8, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(33,  5, 0, 0, 0, 0, 4'b0000, 0, 0, 0));

        #1;
        exp_q.push_back(mk(100, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        compare_out();
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset in RUN, applied between edges.
        run_vec(mk(200, 49, 1, 0, 0, 0, 4'b1111, 1, 1, 0));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(201, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        compare_out();
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(202, 10, 0, 0, 0, 0, 4'b0000, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enable_sequencer.md
Name: enable_sequencer

Overview:
- Power/enable sequencer for a bank of N_CH downstream blocks, each driven by an active-high enable (the inverter-style enable/reset leaf cells).
- On a start request, waits a settle delay, then asserts the enables one channel at a time, LSB first, with a fixed spacing.
- On a stop request, de-asserts them in reverse order.
- A fault input forces all enables low immediately.

Parameters:
- N_CH, 4, number of enable channels (>=1).
- START_DELAY, 16, cycles from start acceptance to enable_out[0] rising (>=1).
- STEP_CYCLES, 8, cycles between successive channel enables/disables (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level/pulse request to begin power-up, sampled on clk.
- stop  input  1  request to begin power-down, sampled on clk.
- fault  input  1  fault condition, active-high, sampled on clk.
- clear  input  1  fault acknowledge; used only when SEQ_FAULT_LATCH_EN is defined.
- enable_out  output  N_CH  per-channel enables, bit 0 first on.
- busy  output  1  high in any state except IDLE and FAULT.
- ready  output  1  high only in RUN (all channels on and settled).
- fault_flag  output  1  high in FAULT.

Behaviour:
- All outputs are registered. Reset (reset=0) asynchronously forces state=IDLE, enable_out=0, busy=0, ready=0, fault_flag=0, and clears the internal counter and index. Reset asserted mid-sequence drops all enables immediately, with no ramp-down.
- States: IDLE, WAIT, UP, RUN, DOWN, FAULT.
- Priority per edge: fault > stop > start.
- IDLE:
  - start=1 and stop=0 -> WAIT; counter loaded with START_DELAY-1.
  - start and stop together -> stay IDLE.
- WAIT:
  - Counter decrements each cycle.
  - At 0 -> UP, enable_out[0]=1, counter reloaded with STEP_CYCLES-1.
  - enable_out[0] therefore rises START_DELAY edges after the edge that sampled start.
- UP:
  - Counter decrements each cycle.
  - At 0, if the highest channel is not yet on: set the next bit and reload.
  - At 0, if all bits are on: -> RUN and ready=1.
  - enable_out[k] rises k*STEP_CYCLES cycles after bit 0. ready rises STEP_CYCLES cycles after bit N_CH-1.
- RUN: holds; start is ignored.
- stop=1 in WAIT -> IDLE on the next edge (no enables are on yet).
- stop=1 in UP or RUN -> DOWN:
  - On that same edge, the highest set bit is cleared and ready=0.
  - Thereafter one further bit is cleared every STEP_CYCLES cycles, MSB to LSB.
  - When enable_out reaches 0 -> IDLE on the same edge.
- DOWN: start and stop are ignored until IDLE is reached.
- fault=1 in any non-FAULT state -> FAULT on the next edge: enable_out=0, ready=0, busy=0, fault_flag=1, counter cleared.
- FAULT exit (without macro): fault=0 -> IDLE on the next edge. A start seen on that same edge is ignored; a new start is required in IDLE.
- Counter width is clog2 of max(START_DELAY, STEP_CYCLES), minimum 1 bit. There is no wrap-around: the counter always reloads before underflow.
- N_CH=1: UP lasts exactly STEP_CYCLES cycles before RUN; DOWN lasts one edge.

Optional Feature:
- Macro SEQ_FAULT_LATCH_EN.
- When defined: FAULT is sticky. It exits to IDLE only on an edge where clear=1 and fault=0; fault=0 alone keeps the block in FAULT.
- When undefined: the clear input is ignored and FAULT exits as soon as fault=0.

Test Plan:
- Defaults; 1-cycle start pulse sampled at edge E -> enable_out=0001 at E+16, 0011 at E+24, 0111 at E+32, 1111 at E+40; ready=1 at E+48; busy=1 from E+1.
- In RUN, 1-cycle stop at edge S -> enable_out=0111 and ready=0 at S, 0011 at S+8, 0001 at S+16, 0000 at S+24, with busy=0 at S+24.
- In UP with enable_out=0011, assert fault -> enable_out=0000 and fault_flag=1 at the next edge; deassert fault -> IDLE and fault_flag=0 at the next edge. With SEQ_FAULT_LATCH_EN, the block stays in FAULT until clear=1.
- In RUN, drive reset low between edges -> enable_out=0000 and ready=0 immediately. Release reset -> IDLE; busy remains 0 with no start.
- In IDLE, start=1 and stop=1 on the same edge -> no state change, enable_out stays 0000. In WAIT, stop -> IDLE with enable_out never asserted.
- In DOWN, pulse start -> ignored; ramp-down completes and the block ends in IDLE.
